// File: rtl/btn_pkg.sv
// Shared button-path constants and types.
// Provides NUM_BTN (also used by btn_ctrl), default debounce/repeat timing,
// the per-channel output record and a counter-width helper.
package btn_pkg;

   localparam int NUM_BTN           = 4;
   localparam int TICK_DIV_DEF      = 100000;  // clk cycles per sample tick
   localparam int STABLE_CNT_DEF    = 8;       // ticks to accept a new level
   localparam int REPEAT_DELAY_DEF  = 500;     // ticks press -> first repeat
   localparam int REPEAT_PERIOD_DEF = 150;     // ticks between later repeats

   // One debounced channel as seen by the top level.
   typedef struct packed {
      logic level;   // debounced level
      logic press;   // one-cycle accepted press (or repeat)
      logic rel;     // one-cycle accepted release
   } btn_ch_t;

   // Bits for a counter that runs 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-FF synchronizer, tick-based stability counter,
// debounced level and press/release pulses.
// Optional auto-repeat, compiled only with BTN_DEBOUNCE_AUTOREPEAT_EN.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   tick      - shared sample strobe from the prescaler
//   btn_in    - raw asynchronous pin
//   ch        - debounced level plus press/release pulses
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int STABLE_CNT    = STABLE_CNT_DEF
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    tick,
   input  logic    btn_in,
   output btn_ch_t ch
);

   localparam int SW = cnt_w(STABLE_CNT);

   logic [1:0]    sync;
   logic          sync_n;
   logic [SW-1:0] stab_cnt;
   logic          level;
   logic          press;
   logic          rel;
   logic          accept;
   logic          rpt_fire;

   assign sync_n = sync[1];

   // The tick that completes STABLE_CNT ticks of a differing level.
   assign accept = tick && (sync_n != level) && (stab_cnt == SW'(STABLE_CNT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         sync     <= '0;
         stab_cnt <= '0;
         level    <= 1'b0;
      end else begin
         sync <= {sync[0], btn_in};
         // Any cycle back at the current level restarts the count, tick or not.
         if (sync_n == level) begin
            stab_cnt <= '0;
         end else if (tick) begin
            if (accept) begin
               level    <= sync_n;
               stab_cnt <= '0;
            end else begin
               stab_cnt <= stab_cnt + 1'b1;
            end
         end
      end
   end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = cnt_w(RMAX);

   logic [RW-1:0] rpt_cnt;
   logic [RW-1:0] rpt_tgt;
   logic          rpt_first;

   // First interval is REPEAT_DELAY, every later one REPEAT_PERIOD.
   assign rpt_tgt  = rpt_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
   // A release acceptance wins over a repeat so press/release never overlap.
   assign rpt_fire = tick && level && !accept && (rpt_cnt == rpt_tgt);

   // Held cleared while the level is low, so counting starts fresh on the
   // tick after the accepted press and stops on release.
   always_ff @(posedge clk) begin
      if (rst || !level) begin
         rpt_cnt   <= '0;
         rpt_first <= 1'b1;
      end else if (tick && !accept) begin
         if (rpt_cnt == rpt_tgt) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
         end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
         end
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   // Pulses register on the same edge as the level, so they appear in the
   // first cycle the new level is visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         press <= (accept && sync_n) || rpt_fire;
         rel   <= accept && !sync_n;
      end
   end

   assign ch = '{level: level, press: press, rel: rel};

endmodule

// File: rtl/btn_debounce.sv
// Four-channel push-button debouncer with a shared sample-tick prescaler.
// Optional auto-repeat of btn_press while held: define BTN_DEBOUNCE_AUTOREPEAT_EN.
// Ports:
//   clk         - single clock
//   rst         - synchronous active-high reset
//   btn_in      - raw asynchronous pins, bit n = BTNn
//   btn_out     - debounced levels (to btn_ctrl btn_in)
//   btn_press   - one-cycle pulse per accepted press (and per repeat)
//   btn_release - one-cycle pulse per accepted release
module btn_debounce
   import btn_pkg::*;
#(
   parameter int TICK_DIV      = TICK_DIV_DEF,
   parameter int STABLE_CNT    = STABLE_CNT_DEF,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_out,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release
);

   localparam int PW = cnt_w(TICK_DIV);

   logic [PW-1:0] pre_cnt;
   logic          tick;

   // Down-counter reloaded on its zero cycle: one tick every TICK_DIV cycles.
   assign tick = (pre_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst || tick) pre_cnt <= PW'(TICK_DIV - 1);
      else             pre_cnt <= pre_cnt - 1'b1;
   end

   btn_ch_t [NUM_BTN-1:0] ch;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .STABLE_CNT    (STABLE_CNT)
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
         ,
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .tick   (tick),
         .btn_in (btn_in[i]),
         .ch     (ch[i])
      );

      assign btn_out[i]     = ch[i].level;
      assign btn_press[i]   = ch[i].press;
      assign btn_release[i] = ch[i].rel;
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce (TICK_DIV=4, STABLE_CNT=3,
// REPEAT_DELAY=5, REPEAT_PERIOD=2). Stimulus pushes each expected pulse
// (press/release/level and the edge it must land on); a monitor pops on
// every observed pulse.
module tb_btn_debounce;

   localparam int TD = 4;
   localparam int SC = 3;
   localparam int RD = 5;
   localparam int RP = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn_in = 4'h0;
   logic [3:0] btn_out;
   logic [3:0] btn_press;
   logic [3:0] btn_release;

   int cyc    = 0;   // posedge count since the last reset edge
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] out;
      int         at;
   } exp_t;

   exp_t exp_q[$];

   btn_debounce #(
      .TICK_DIV      (TD),
      .STABLE_CNT    (SC),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in),
      .btn_out     (btn_out),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Prescaler loads TD-1 in reset and counts down, so ticks land on edges
   // TD, 2*TD, ... after reset. A pin driven just after edge e reaches the
   // stability logic at edge e+3; acceptance is the SC-th tick from there.
   function automatic int acc_edge(input int e);
      int m;
      m = e + 3;
      while (m % TD != 0) m++;
      return m + (SC - 1) * TD;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] p, input logic [3:0] r, input logic [3:0] o, input int at);
      exp_t x;
      x.press = p;
      x.rel   = r;
      x.out   = o;
      x.at    = at;
      exp_q.push_back(x);
   endtask

   task automatic drive(input logic [3:0] v, output int e);
      @(posedge clk);
      #1;
      btn_in = v;
      e = cyc;
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected pulses never seen", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: every cycle with any pulse must match the head of the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && ((btn_press | btn_release) != 4'h0)) begin
            checks++;
            if ((btn_press & btn_release) != 4'h0) begin
               errors++;
               $display("FAIL overlap @%0d: press %h release %h both set", cyc, btn_press, btn_release);
            end
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse @%0d: press %h release %h out %h", cyc, btn_press, btn_release, btn_out);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if ({btn_press, btn_release, btn_out} !== {e.press, e.rel, e.out} || cyc != e.at) begin
                  errors++;
                  $display("FAIL pulse @%0d: press %h release %h out %h, expected press %h release %h out %h @%0d",
                           cyc, btn_press, btn_release, btn_out, e.press, e.rel, e.out, e.at);
               end
            end
         end
      end
   end

   initial begin
      int e;
      int t;
      int t1;

      // Reset state
      rst    = 1'b1;
      btn_in = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out", btn_out, 4'h0);
      chk("reset_press", btn_press, 4'h0);
      chk("reset_release", btn_release, 4'h0);
      rst = 1'b0;

      // Single clean press/release on channel 0
      drive(4'h1, e);
      t = acc_edge(e);
      push(4'h1, 4'h0, 4'h1, t);
      wait_until(t - 1);
      chk("pre_accept_out", btn_out, 4'h0);
      wait_until(t + 1);
      chk("press_level", btn_out, 4'h1);
      drain("single_press");
      wait_until(t + 8);
      drive(4'h0, e);
      t = acc_edge(e);
      push(4'h0, 4'h1, 4'h0, t);
      drain("single_release");

      // Channel 1 toggled every 2 ticks for 20 ticks: never accepted
      for (int k = 0; k < 5; k++) begin
         drive(4'h2, e);
         repeat (7) @(posedge clk);
         drive(4'h0, e);
         repeat (7) @(posedge clk);
      end
      repeat (16) @(posedge clk);
      #1;
      chk("glitch_out", btn_out, 4'h0);

      // All four channels together
      drive(4'hF, e);
      t = acc_edge(e);
      push(4'hF, 4'h0, 4'hF, t);
      drain("all_press");
      wait_until(t + 8);
      drive(4'h0, e);
      t = acc_edge(e);
      push(4'h0, 4'hF, 4'h0, t);
      drain("all_release");
      chk("all_release_out", btn_out, 4'h0);

      // Reset mid-debounce on channel 2 after two counted ticks
      drive(4'h4, e);
      t1 = acc_edge(e) - (SC - 1) * TD;
      wait_until(t1 + TD);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_out", btn_out, 4'h0);
      chk("midrst_press", btn_press, 4'h0);
      chk("midrst_release", btn_release, 4'h0);
      rst = 1'b0;
      t = acc_edge(0);
      push(4'h4, 4'h0, 4'h4, t);
      wait_until(t - 1);
      chk("post_rst_pending", btn_out, 4'h0);
      drain("post_rst_press");
      wait_until(t + 4);
      chk("post_rst_level", btn_out, 4'h4);
      drive(4'h0, e);
      t = acc_edge(e);
      push(4'h0, 4'h4, 4'h0, t);
      drain("post_rst_release");

      // Channel 3 held 12 ticks after acceptance
      drive(4'h8, e);
      t = acc_edge(e);
      push(4'h8, 4'h0, 4'h8, t);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
      for (int r = 0; r < 4; r++) push(4'h8, 4'h0, 4'h8, t + (RD + r * RP) * TD);
`endif
      // Release so the drop is accepted on tick 12
      wait_until(t + (RD + 2 * RP) * TD - 1);
      drive(4'h0, e);
      push(4'h0, 4'h8, 4'h0, acc_edge(e));
      drain("hold_repeat");
      repeat (8) @(posedge clk);
      #1;
      chk("final_out", btn_out, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
